// File: rtl/instruction_rom_sync.sv
// instruction_rom_sync: run-time loadable instruction memory with 1-cycle registered reads
// Define ROM_BOUNDS_CHECK_EN to return DEFAULT_WORD and pulse oFault on reads past the loaded program.
module instruction_rom_sync #(
    parameter int                WORD_W       = 28,
    parameter int                ADDR_W       = 8,
    parameter logic [WORD_W-1:0] DEFAULT_WORD = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iReadEnable,
    input  logic [15:0]       iAddress,
    output logic [WORD_W-1:0] oInstruction,
    output logic              oValid,
    input  logic              iLoadStart,
    input  logic              iLoadValid,
    input  logic [WORD_W-1:0] iLoadData,
    input  logic              iLoadLast,
    output logic              oLoadReady,
    output logic              oBusy,
    output logic [ADDR_W:0]   oLoadCount,
    output logic              oFault
);
    typedef enum logic {LOAD, RUN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              oob;
    logic [WORD_W-1:0] mem [2**ADDR_W];
    assign oLoadReady = (state == LOAD);
    assign oBusy      = (state == LOAD);
`ifdef ROM_BOUNDS_CHECK_EN
    assign oob = iAddress >= 16'(oLoadCount);
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^iAddress[15:ADDR_W];
    assign oob            = 1'b0;
`endif
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= LOAD;
            ptr          <= '0;
            oLoadCount   <= '0;
            oInstruction <= DEFAULT_WORD;
            oValid       <= 1'b0;
            oFault       <= 1'b0;
        end else if (state == LOAD) begin
            oInstruction <= DEFAULT_WORD;
            oValid       <= 1'b0;
            oFault       <= 1'b0;
            if (iLoadStart) begin
                ptr        <= '0;
                oLoadCount <= '0;
            end else if (iLoadValid) begin
                ptr        <= ptr + 1'b1;
                oLoadCount <= oLoadCount + 1'b1;
                if (iLoadLast || &ptr) state <= RUN;
            end
        end else begin
            if (iLoadStart) begin
                state      <= LOAD;
                ptr        <= '0;
                oLoadCount <= '0;
            end
            oValid <= iReadEnable;
            oFault <= iReadEnable & oob;
            if (iReadEnable) oInstruction <= oob ? DEFAULT_WORD : mem[iAddress[ADDR_W-1:0]];
        end
    end
    // Reset-free write port keeps the array mappable to block RAM; contents survive Reset.
    always_ff @(posedge Clock) begin
        if (!Reset && state == LOAD && iLoadValid && !iLoadStart) mem[ptr] <= iLoadData;
    end
endmodule

// File: tb/tb_instruction_rom_sync.sv
// tb_instruction_rom_sync: scoreboard bench for instruction_rom_sync (default 28-bit x 256 words).
module tb_instruction_rom_sync;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        iReadEnable;
    logic [15:0] iAddress;
    logic [27:0] oInstruction;
    logic        oValid;
    logic        iLoadStart;
    logic        iLoadValid;
    logic [27:0] iLoadData;
    logic        iLoadLast;
    logic        oLoadReady;
    logic        oBusy;
    logic [8:0]  oLoadCount;
    logic        oFault;

    instruction_rom_sync dut (
        .Clock(Clock), .Reset(Reset), .iReadEnable(iReadEnable), .iAddress(iAddress),
        .oInstruction(oInstruction), .oValid(oValid), .iLoadStart(iLoadStart),
        .iLoadValid(iLoadValid), .iLoadData(iLoadData), .iLoadLast(iLoadLast),
        .oLoadReady(oLoadReady), .oBusy(oBusy), .oLoadCount(oLoadCount), .oFault(oFault)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [27:0] d;
        logic        f;
        int          c;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
`ifdef ROM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    always @(negedge Clock) begin
        if (oValid) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got instr=%0h want no output", oInstruction);
            end else begin
                e = q.pop_front();
                check("rd_data", 32'(oInstruction), 32'(e.d));
                check("rd_fault", 32'(oFault), 32'(e.f));
                check("rd_latency", cyc, e.c + 1);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load(input int n, input logic [27:0] first, input bit last);
        for (int i = 0; i < n; i++) begin
            iLoadValid = 1'b1;
            iLoadData  = first + 28'(i);
            iLoadLast  = last && (i == n - 1);
            tick();
        end
        iLoadValid = 1'b0;
        iLoadLast  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [27:0] d, input logic f);
        iReadEnable = 1'b1;
        iAddress    = a;
        q.push_back('{d: d, f: f, c: cyc});
        tick();
        iReadEnable = 1'b0;
    endtask

    task automatic restart();
        iLoadStart = 1'b1;
        tick();
        iLoadStart = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1; iReadEnable = 1'b0; iAddress = '0; iLoadStart = 1'b0;
        iLoadValid = 1'b0; iLoadData = '0; iLoadLast = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        check("rst_instr", 32'(oInstruction), 0);
        check("rst_valid", 32'(oValid), 0);
        check("rst_fault", 32'(oFault), 0);
        check("rst_count", 32'(oLoadCount), 0);
        check("rst_busy", 32'(oBusy), 1);
        check("rst_ready", 32'(oLoadReady), 1);
        // Full-depth load without iLoadLast: auto-transition after the 256th word.
        load(255, 28'h1000000, 1'b0);
        check("full_cnt255", 32'(oLoadCount), 255);
        check("full_busy255", 32'(oBusy), 1);
        load(1, 28'h10000FF, 1'b0);
        check("full_cnt", 32'(oLoadCount), 256);
        check("full_busy", 32'(oBusy), 0);
        check("full_ready", 32'(oLoadReady), 0);
        rd(16'd255, 28'h10000FF, 1'b0);
        rd(16'd0, 28'h1000000, 1'b0);
        rd(16'd128, 28'h1000080, 1'b0);
        // Reset from RUN, then an 8-word program.
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("rst2_count", 32'(oLoadCount), 0);
        check("rst2_busy", 32'(oBusy), 1);
        load(7, 28'h1, 1'b0);
        check("p8_busy_pre", 32'(oBusy), 1);
        load(1, 28'h8, 1'b1);
        check("p8_count", 32'(oLoadCount), 8);
        check("p8_busy", 32'(oBusy), 0);
        for (int i = 0; i < 8; i++) rd(16'(i), 28'(i + 1), 1'b0);
        rd(16'd8, BC ? 28'h0 : 28'h1000008, BC);
        rd(16'h0100, BC ? 28'h0 : 28'h1, BC);
        rd(16'hFFFF, BC ? 28'h0 : 28'h10000FF, BC);
        // Reload from RUN; reads during LOAD give nothing.
        restart();
        check("rl_busy", 32'(oBusy), 1);
        check("rl_count", 32'(oLoadCount), 0);
        iReadEnable = 1'b1; iAddress = 16'd0;
        tick();
        check("rl_rd_valid", 32'(oValid), 0);
        check("rl_rd_instr", 32'(oInstruction), 0);
        iReadEnable = 1'b0;
        load(3, 28'hA1, 1'b1);
        check("rl_count3", 32'(oLoadCount), 3);
        rd(16'd0, 28'hA1, 1'b0);
        rd(16'd1, 28'hA2, 1'b0);
        rd(16'd2, 28'hA3, 1'b0);
        rd(16'd3, BC ? 28'h0 : 28'h4, BC);
        // iLoadStart coincident with an accept at ptr=4 drops the word.
        restart();
        load(4, 28'hB0, 1'b0);
        check("co_count4", 32'(oLoadCount), 4);
        iLoadStart = 1'b1; iLoadValid = 1'b1; iLoadData = 28'hABCDEF0;
        tick();
        iLoadStart = 1'b0; iLoadValid = 1'b0;
        check("co_count0", 32'(oLoadCount), 0);
        check("co_busy", 32'(oBusy), 1);
        load(2, 28'hC0, 1'b1);
        check("co_count2", 32'(oLoadCount), 2);
        rd(16'd0, 28'hC0, 1'b0);
        rd(16'd1, 28'hC1, 1'b0);
        rd(16'd4, BC ? 28'h0 : 28'h5, BC);
        rd(16'd3, BC ? 28'h0 : 28'hB3, BC);
        // Reset mid-load aborts, then a full reload.
        restart();
        load(5, 28'hD0, 1'b0);
        check("ab_count5", 32'(oLoadCount), 5);
        Reset = 1'b1; iReadEnable = 1'b1; tick(); Reset = 1'b0; iReadEnable = 1'b0;
        check("ab_count", 32'(oLoadCount), 0);
        check("ab_busy", 32'(oBusy), 1);
        check("ab_valid", 32'(oValid), 0);
        load(10, 28'hE0, 1'b1);
        check("ab_count10", 32'(oLoadCount), 10);
        for (int i = 0; i < 10; i++) rd(16'(i), 28'hE0 + 28'(i), 1'b0);
        tick(); tick();
        check("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
